// File: rtl/fifo_vr_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_vr_if : valid/ready/data handshake bundle for one side of fifo_vr. Rev 1.0
// ---------------------------------------------------------------------------
interface fifo_vr_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/fifo_vr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_vr : synchronous valid/ready FIFO, any depth, optional output register. Rev 1.0
// ---------------------------------------------------------------------------
module fifo_vr #(
  parameter  int WIDTH     = 64,
  parameter  int DEPTH     = 16,
  parameter  int REG_OUT   = 0,
  parameter  int AF_THRESH = DEPTH - 2,
  parameter  int AE_THRESH = 2,
  localparam int CW        = $clog2(DEPTH + REG_OUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          clr_hwm,
  fifo_vr_if.slave      in_if,
  fifo_vr_if.master     out_if,
  output logic [CW-1:0] count,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] hwm
);

  localparam int              PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              RW    = $clog2(DEPTH + 1);
  localparam logic [PW-1:0]   LAST  = PW'(DEPTH - 1);
  localparam logic [RW-1:0]   RFULL = RW'(DEPTH);

  logic [WIDTH-1:0] ram [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [RW-1:0]    ram_cnt;
  logic             push, pop, ram_we, ram_rd;
  logic [CW-1:0]    count_next;
  int               count_i;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] incr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign in_if.ready = !flush && (ram_cnt < RFULL);
  assign push        = in_if.valid && in_if.ready;
  assign pop         = out_if.valid && out_if.ready;
  assign count_next  = flush ? '0 : count + CW'(push) - CW'(pop);

  assign count_i      = int'(count);
  assign almost_full  = (count_i >= AF_THRESH);
  assign almost_empty = (count_i <= AE_THRESH);

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic             oreg_valid;
      logic [WIDTH-1:0] oreg_data;
      logic             load;
      logic             bypass;

      // The register refills whenever it is empty or drained; with the RAM empty
      // the incoming word goes straight into it so a stream never bubbles.
      assign load   = !flush && (!oreg_valid || pop);
      assign bypass = load && (ram_cnt == '0);
      assign ram_rd = load && (ram_cnt != '0);
      assign ram_we = push && !bypass;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          oreg_valid <= 1'b0;
          oreg_data  <= '0;
        end else if (flush) begin
          oreg_valid <= 1'b0;
        end else if (load) begin
          oreg_valid <= (ram_cnt != '0) || push;
          if (ram_cnt != '0)
            oreg_data <= ram[rd_ptr];
          else if (push)
            oreg_data <= in_if.data;
        end
      end

      assign out_if.valid = !flush && oreg_valid;
      assign out_if.data  = oreg_data;
    end else begin : g_fwft
      assign ram_rd       = pop;
      assign ram_we       = push;
      assign out_if.valid = !flush && (ram_cnt != '0);
      assign out_if.data  = ram[rd_ptr];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      ram_cnt <= '0;
      count   <= '0;
      hwm     <= '0;
    end else begin
      count <= count_next;
      hwm   <= (clr_hwm || (count_next > hwm)) ? count_next : hwm;
      if (flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        ram_cnt <= '0;
      end else begin
        if (ram_we) wr_ptr <= incr(wr_ptr);
        if (ram_rd) rd_ptr <= incr(rd_ptr);
        ram_cnt <= ram_cnt + RW'(ram_we) - RW'(ram_rd);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_ptr] <= in_if.data;
  end

endmodule
`default_nettype wire
